// File: rtl/mem_bank_ctrl.sv
// Bank-select control register with settle delay and wait-stated memory access.
// Optional MEM_BANK_LOCK_EN: ctrl_reg[4] becomes a sticky write-lock bit.
module mem_bank_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int WAIT_STATES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       ctrl_wr,
    input  logic       bank_inc,
    input  logic       mem_req,
    output logic [7:0] ctrl_reg,
    output logic       cs_en_,
    output logic       mem_ack,
    output logic       busy,
    output logic       wrap
);

    localparam int MAXC = (SETTLE_CYCLES > WAIT_STATES) ? SETTLE_CYCLES : WAIT_STATES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCESS,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ctrl_q, ctrl_d;
    logic          cs_en_q, cs_en_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          wrap_q, wrap_d;
    logic          wr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        wrap_d  = 1'b0;
`ifdef MEM_BANK_LOCK_EN
        wr_ok = ctrl_wr && !ctrl_q[4];
`else
        wr_ok = ctrl_wr;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_ok) begin
                    ctrl_d = data_in;
                    if (data_in[7:5] != ctrl_q[7:5]) state_d = SETTLE;
                end else if (bank_inc) begin
                    ctrl_d[7:5] = ctrl_q[7:5] + 3'd1;
                    wrap_d      = (ctrl_q[7:5] == 3'd7);
                    state_d     = SETTLE;
                end else if (mem_req) begin
                    state_d = ACCESS;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they align with it
        cs_en_d = !((state_d == ACCESS) || (state_d == ACK));
        ack_d   = (state_d == ACK);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= 8'h00;
            cs_en_q <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            cs_en_q <= cs_en_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ctrl_reg = ctrl_q;
    assign cs_en_   = cs_en_q;
    assign mem_ack  = ack_q;
    assign busy     = busy_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl: timeline model of busy windows and events.
// Honours MEM_BANK_LOCK_EN the same way as the design.
module tb_mem_bank_ctrl;

    localparam int S  = 2;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       ctrl_wr = 1'b0;
    logic       bank_inc = 1'b0;
    logic       mem_req = 1'b0;
    logic [7:0] ctrl_reg;
    logic       cs_en_, mem_ack, busy, wrap;

    mem_bank_ctrl #(.SETTLE_CYCLES(S), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .ctrl_wr(ctrl_wr),
        .bank_inc(bank_inc), .mem_req(mem_req), .ctrl_reg(ctrl_reg),
        .cs_en_(cs_en_), .mem_ack(mem_ack), .busy(busy), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        bit is_ack;
    } ev_t;

    ev_t sb[$];
    int  edge_n = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    // Model: register value plus edge-indexed busy and chip-select windows
    logic [7:0] m_ctrl = 8'h00;
    int  busy_lo = 0;
    int  busy_end = -10;
    int  acc_lo = 0;
    int  acc_hi = -10;
    bit  started = 0;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at edge %0d", nm, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_ctrl   = 8'h00;
        busy_lo  = 0;
        busy_end = -10;
        acc_lo   = 0;
        acc_hi   = -10;
        sb.delete();
    endtask

    task automatic step(input bit wr, input bit inc, input bit req, input logic [7:0] din);
        int  e;
        bit  wr_ok;
        ev_t ev;
        e = edge_n;
        chk("ctrl_reg", ctrl_reg, m_ctrl);
        chk("busy", {7'd0, busy}, {7'd0, (e >= busy_lo && e <= busy_end)});
        chk("cs_en_", {7'd0, cs_en_}, {7'd0, !(e >= acc_lo && e <= acc_hi)});
        ctrl_wr  = wr;
        bank_inc = inc;
        mem_req  = req;
        data_in  = din;
        started  = 0;
        e = edge_n + 1;
        if (e >= busy_end + 2) begin
            wr_ok = wr;
`ifdef MEM_BANK_LOCK_EN
            if (m_ctrl[4]) wr_ok = 0;
`endif
            if (wr_ok) begin
                if (din[7:5] != m_ctrl[7:5]) begin
                    busy_lo  = e;
                    busy_end = e + S - 1;
                end
                m_ctrl = din;
            end else if (inc) begin
                if (m_ctrl[7:5] == 3'd7) begin
                    ev.e = e; ev.is_ack = 0; sb.push_back(ev);
                end
                m_ctrl[7:5] = 3'((int'(m_ctrl[7:5]) + 1) % 8);
                busy_lo  = e;
                busy_end = e + S - 1;
            end else if (req) begin
                acc_lo   = e;
                acc_hi   = e + WS;
                busy_lo  = e;
                busy_end = e + WS;
                ev.e = e + WS; ev.is_ack = 1; sb.push_back(ev);
                started = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (edge_n + 1 >= busy_end + 2) break;
            step(0, 0, 0, 8'h00);
        end
        if (edge_n + 1 < busy_end + 2) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle: got busy expected idle at edge %0d", edge_n);
        end
    endtask

    // Monitor: every ack/wrap pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_ack || wrap) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL event: got ack=%0b wrap=%0b expected none at edge %0d",
                             mem_ack, wrap, edge_n);
                end else if (sb[0].e != edge_n || sb[0].is_ack != mem_ack || wrap == mem_ack) begin
                    n_fail++;
                    $display("FAIL event: got ack=%0b wrap=%0b at edge %0d expected %s at edge %0d",
                             mem_ack, wrap, edge_n, sb[0].is_ack ? "ack" : "wrap", sb[0].e);
                    void'(sb.pop_front());
                end else begin
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].e < edge_n) begin
                n_chk++; n_fail++;
                $display("FAIL missing_event: got none expected %s at edge %0d",
                         sb[0].is_ack ? "ack" : "wrap", sb[0].e);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit pend;
        bit served;
        logic [7:0] din;
        pend = 0;
        served = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", ctrl_reg, 8'h00);
        chk("rst_cs_en_", {7'd0, cs_en_}, 8'h01);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_ack", {7'd0, mem_ack}, 8'h00);
        chk("rst_wrap", {7'd0, wrap}, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        step(1, 0, 0, 8'hA0);
        wait_idle();
        step(1, 0, 0, 8'hA5);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        wait_idle();
        step(1, 0, 0, 8'hE3);
        wait_idle();
        step(0, 1, 0, 8'h00);
        wait_idle();
        step(1, 1, 0, 8'h40);
        wait_idle();
        step(0, 0, 1, 8'h00);
        step(1, 0, 1, 8'h20);
        step(1, 0, 0, 8'h20);
        wait_idle();
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        wait_idle();

        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) pend = 1;
            din = 8'($urandom);
            if ($urandom_range(0, 2) == 0) din[7:5] = m_ctrl[7:5];
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, pend, din);
            if (started) served = 1;
            if (pend && served && $urandom_range(0, 1) == 1) begin
                pend = 0;
                served = 0;
            end
        end
        wait_idle();

        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        @(posedge clk);
        #2 reset = 1'b1;
        mem_req = 1'b0;
        #1;
        chk("mid_rst_ctrl", ctrl_reg, 8'h00);
        chk("mid_rst_cs_en_", {7'd0, cs_en_}, 8'h01);
        chk("mid_rst_busy", {7'd0, busy}, 8'h00);
        chk("mid_rst_ack", {7'd0, mem_ack}, 8'h00);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

`ifdef MEM_BANK_LOCK_EN
        step(1, 0, 0, 8'h10);
        wait_idle();
        step(1, 0, 0, 8'h60);
        wait_idle();
        step(0, 1, 0, 8'h00);
        wait_idle();
        step(0, 0, 0, 8'h00);
        chk("lock_ctrl", ctrl_reg, 8'h30);
`endif

        step(1, 0, 0, 8'h00);
        wait_idle();
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("sb_empty", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
